// File: rtl/drc_ass_sched.sv
// drc_ass_sched: four one-entry request slots (urch, up, dn, rsh) feeding a
// single registered offer to the DRC packet assembler over valid/ready.
// Arbitration is fixed priority (urch > up > dn > rsh). A slot whose age has
// reached AGE_LIMIT overrides fixed priority, so no source can be starved.
module drc_ass_sched #(
    parameter logic [5:0]       URCHRP    = 6'h6,
    parameter logic [5:0]       RSHRQ     = 6'h7,
    parameter logic [5:0]       UPRSP     = 6'h3,
    parameter logic [5:0]       DNRSP     = 6'h4,
    parameter int               AGE_W     = 4,
    parameter logic [AGE_W-1:0] AGE_LIMIT = 4'd8
) (
    input  logic        iClk,
    input  logic        iResetN,
    input  logic        iUrchVld,
    input  logic [15:0] iUrchSrcAddr,
    input  logic [4:0]  iUrchTargtPort,
    output logic        oUrchRdy,
    input  logic        iUpVld,
    output logic        oUpRdy,
    input  logic        iDnVld,
    output logic        oDnRdy,
    input  logic        iRshVld,
    output logic        oRshRdy,
    output logic        oSchVld,
    output logic [5:0]  oSchType,
    output logic [15:0] oSchSrcAddr,
    output logic [4:0]  oSchTargtPort,
    output logic [1:0]  oSchId,
    input  logic        iSchRdy,
    output logic        oStarveEvt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Index of the lowest set bit; slot 0 (urch) has the highest priority.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Packet type code for a given source slot.
    function automatic logic [5:0] type_of(input logic [1:0] id);
        logic [5:0] t;
        case (id)
            2'd0:    t = URCHRP;
            2'd1:    t = UPRSP;
            2'd2:    t = DNRSP;
            2'd3:    t = RSHRQ;
            default: t = 6'h00;
        endcase
        return t;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [3:0]         pending_r;
    logic [AGE_W-1:0]   age_r [4];
    logic [15:0]        urch_addr_r;
    logic [4:0]         urch_port_r;
    logic [3:0]         req_vld_s;
    logic [3:0]         aged_s;
    logic [1:0]         fixed_win_s;
    logic [1:0]         win_s;
    logic               load_s;
    logic               drain_s;
    logic [5:0]         sch_type_r;
    logic [15:0]        sch_addr_r;
    logic [4:0]         sch_port_r;
    logic [1:0]         sch_id_r;
    logic               starve_r;

    assign req_vld_s     = {iRshVld, iDnVld, iUpVld, iUrchVld};
    assign oUrchRdy      = ~pending_r[0];
    assign oUpRdy        = ~pending_r[1];
    assign oDnRdy        = ~pending_r[2];
    assign oRshRdy       = ~pending_r[3];
    assign oSchVld       = (state_r == ST_OFFER);
    assign oSchType      = sch_type_r;
    assign oSchSrcAddr   = sch_addr_r;
    assign oSchTargtPort = sch_port_r;
    assign oSchId        = sch_id_r;
    assign oStarveEvt    = starve_r;

    // Pick the winner: oldest-saturated slot first, otherwise fixed priority.
    always_comb begin
        aged_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            aged_s[i] = pending_r[i] && (age_r[i] == AGE_LIMIT);
        end
        fixed_win_s = first_set(pending_r);
        if (|aged_s) begin
            win_s = first_set(aged_s);
        end else begin
            win_s = fixed_win_s;
        end
    end

    // Offer FSM next state; a load refills the offer with zero bubble.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        drain_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|pending_r) begin
                    load_s       = 1'b1;
                    next_state_s = ST_OFFER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (iSchRdy) begin
                    if (|pending_r) begin
                        load_s       = 1'b1;
                        next_state_s = ST_OFFER;
                    end else begin
                        drain_s      = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_OFFER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Offer FSM state register.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Offer payload registers; held stable while the offer is outstanding.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            sch_type_r <= 6'h00;
            sch_addr_r <= 16'h0000;
            sch_port_r <= 5'd0;
            sch_id_r   <= 2'd0;
            starve_r   <= 1'b0;
        end else if (load_s) begin
            sch_type_r <= type_of(win_s);
            sch_addr_r <= (win_s == 2'd0) ? urch_addr_r : 16'h0000;
            sch_port_r <= (win_s == 2'd0) ? urch_port_r : 5'd0;
            sch_id_r   <= win_s;
            starve_r   <= (win_s != fixed_win_s);
        end else if (drain_s) begin
            sch_type_r <= 6'h00;
            sch_addr_r <= 16'h0000;
            sch_port_r <= 5'd0;
            sch_id_r   <= 2'd0;
            starve_r   <= 1'b0;
        end else begin
            starve_r   <= 1'b0;
        end
    end

    // Slot pending bits and saturating ages; a loaded slot is emptied.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            pending_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_s && (win_s == 2'(i))) begin
                    pending_r[i] <= 1'b0;
                    age_r[i]     <= '0;
                end else if (pending_r[i]) begin
                    if (age_r[i] != AGE_LIMIT) begin
                        age_r[i] <= age_r[i] + {{(AGE_W-1){1'b0}}, 1'b1};
                    end else begin
                        age_r[i] <= age_r[i];
                    end
                end else if (req_vld_s[i]) begin
                    pending_r[i] <= 1'b1;
                    age_r[i]     <= '0;
                end else begin
                    age_r[i]     <= '0;
                end
            end
        end
    end

    // Unreachable-rsp payload captured together with its request.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            urch_addr_r <= 16'h0000;
            urch_port_r <= 5'd0;
        end else if (iUrchVld && !pending_r[0]) begin
            urch_addr_r <= iUrchSrcAddr;
            urch_port_r <= iUrchTargtPort;
        end else begin
            urch_addr_r <= urch_addr_r;
            urch_port_r <= urch_port_r;
        end
    end

endmodule

// File: tb/tb_drc_ass_sched.sv
// Directed bench for drc_ass_sched: inputs change 1 time unit after the
// rising edge, outputs are checked right after that, away from the edge.
module tb_drc_ass_sched;

    logic        iClk;
    logic        iResetN;
    logic        iUrchVld;
    logic [15:0] iUrchSrcAddr;
    logic [4:0]  iUrchTargtPort;
    logic        oUrchRdy;
    logic        iUpVld;
    logic        oUpRdy;
    logic        iDnVld;
    logic        oDnRdy;
    logic        iRshVld;
    logic        oRshRdy;
    logic        oSchVld;
    logic [5:0]  oSchType;
    logic [15:0] oSchSrcAddr;
    logic [4:0]  oSchTargtPort;
    logic [1:0]  oSchId;
    logic        iSchRdy;
    logic        oStarveEvt;

    int n_checks;
    int n_fails;

    drc_ass_sched dut (
        .iClk           (iClk),
        .iResetN        (iResetN),
        .iUrchVld       (iUrchVld),
        .iUrchSrcAddr   (iUrchSrcAddr),
        .iUrchTargtPort (iUrchTargtPort),
        .oUrchRdy       (oUrchRdy),
        .iUpVld         (iUpVld),
        .oUpRdy         (oUpRdy),
        .iDnVld         (iDnVld),
        .oDnRdy         (oDnRdy),
        .iRshVld        (iRshVld),
        .oRshRdy        (oRshRdy),
        .oSchVld        (oSchVld),
        .oSchType       (oSchType),
        .oSchSrcAddr    (oSchSrcAddr),
        .oSchTargtPort  (oSchTargtPort),
        .oSchId         (oSchId),
        .iSchRdy        (iSchRdy),
        .oStarveEvt     (oStarveEvt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk_offer(input string tag, input logic [1:0] id, input logic [5:0] typ,
                             input logic [15:0] addr, input logic [4:0] port, input logic starve);
        chk({tag, ".vld"},    32'(oSchVld),       32'd1);
        chk({tag, ".id"},     32'(oSchId),        32'(id));
        chk({tag, ".type"},   32'(oSchType),      32'(typ));
        chk({tag, ".addr"},   32'(oSchSrcAddr),   32'(addr));
        chk({tag, ".port"},   32'(oSchTargtPort), 32'(port));
        chk({tag, ".starve"}, 32'(oStarveEvt),    32'(starve));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".vld"},    32'(oSchVld),       32'd0);
        chk({tag, ".id"},     32'(oSchId),        32'd0);
        chk({tag, ".type"},   32'(oSchType),      32'd0);
        chk({tag, ".addr"},   32'(oSchSrcAddr),   32'd0);
        chk({tag, ".port"},   32'(oSchTargtPort), 32'd0);
        chk({tag, ".starve"}, 32'(oStarveEvt),    32'd0);
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp_rdy);
        chk(tag, 32'({oRshRdy, oDnRdy, oUpRdy, oUrchRdy}), 32'(exp_rdy));
    endtask

    initial begin
        logic [1:0] exp_id;
        logic [5:0] exp_type;
        n_checks       = 0;
        n_fails        = 0;
        iResetN        = 1'b0;
        iUrchVld       = 1'b0;
        iUrchSrcAddr   = 16'h0000;
        iUrchTargtPort = 5'd0;
        iUpVld         = 1'b0;
        iDnVld         = 1'b0;
        iRshVld        = 1'b0;
        iSchRdy        = 1'b0;
        #12;
        chk_idle("reset");
        chk_rdy("reset.rdy", 4'b1111);
        iResetN = 1'b1;
        tick();

        // 1: single urch request, latency one edge after capture
        iUrchVld = 1'b1; iUrchSrcAddr = 16'hABCD; iUrchTargtPort = 5'd9;
        tick();
        iUrchVld = 1'b0; iUrchSrcAddr = 16'h0000; iUrchTargtPort = 5'd0;
        chk("t1.captured_vld", 32'(oSchVld), 32'd0);
        chk_rdy("t1.rdy_pending", 4'b1110);
        tick();
        chk_offer("t1.offer", 2'd0, 6'h6, 16'hABCD, 5'd9, 1'b0);
        chk_rdy("t1.rdy_loaded", 4'b1111);

        // 6: accept with every slot empty clears the offer
        iSchRdy = 1'b1;
        tick();
        chk_idle("t6.drain");

        // 2: all four together, back-to-back offers in priority order
        iUrchVld = 1'b1; iUpVld = 1'b1; iDnVld = 1'b1; iRshVld = 1'b1;
        iUrchSrcAddr = 16'h1234; iUrchTargtPort = 5'd3;
        tick();
        iUrchVld = 1'b0; iUpVld = 1'b0; iDnVld = 1'b0; iRshVld = 1'b0;
        chk("t2.capture_vld", 32'(oSchVld), 32'd0);
        chk_rdy("t2.rdy_all_pending", 4'b0000);
        tick();
        chk_offer("t2.urch", 2'd0, 6'h6, 16'h1234, 5'd3, 1'b0);
        tick();
        chk_offer("t2.up", 2'd1, 6'h3, 16'h0000, 5'd0, 1'b0);
        tick();
        chk_offer("t2.dn", 2'd2, 6'h4, 16'h0000, 5'd0, 1'b0);
        tick();
        chk_offer("t2.rsh", 2'd3, 6'h7, 16'h0000, 5'd0, 1'b0);
        chk_rdy("t2.rdy_empty", 4'b1111);
        tick();
        chk_idle("t2.drain");

        // 3: held offer under back-pressure, new up request waits
        iSchRdy = 1'b0;
        iDnVld  = 1'b1;
        tick();
        iDnVld  = 1'b0;
        tick();
        chk_offer("t3.dn", 2'd2, 6'h4, 16'h0000, 5'd0, 1'b0);
        iUpVld = 1'b1;
        tick();
        iUpVld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_offer("t3.hold", 2'd2, 6'h4, 16'h0000, 5'd0, 1'b0);
            chk_rdy("t3.hold_rdy", 4'b1101);
            tick();
        end
        iSchRdy = 1'b1;
        tick();
        chk_offer("t3.up", 2'd1, 6'h3, 16'h0000, 5'd0, 1'b0);
        tick();
        chk_idle("t3.drain");

        // 4: rsh starved by urch/up refilled every cycle until its age hits 8
        iUrchVld = 1'b1; iUpVld = 1'b1; iRshVld = 1'b1;
        iUrchSrcAddr = 16'h5A5A; iUrchTargtPort = 5'd17;
        tick();
        iRshVld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_id   = (k % 2 == 1) ? 2'd0 : 2'd1;
            exp_type = (k % 2 == 1) ? 6'h6 : 6'h3;
            chk("t4.prio_id", 32'(oSchId), 32'(exp_id));
            chk("t4.prio_type", 32'(oSchType), 32'(exp_type));
            chk("t4.prio_starve", 32'(oStarveEvt), 32'd0);
        end
        tick();
        iUrchVld = 1'b0; iUpVld = 1'b0;
        chk_offer("t4.aged_rsh", 2'd3, 6'h7, 16'h0000, 5'd0, 1'b1);
        tick();
        chk_offer("t4.after_urch", 2'd0, 6'h6, 16'h5A5A, 5'd17, 1'b0);
        tick();
        chk_offer("t4.after_up", 2'd1, 6'h3, 16'h0000, 5'd0, 1'b0);
        tick();
        chk_idle("t4.drain");

        // 5: async reset while offering with three slots still pending
        iSchRdy = 1'b0;
        iUrchVld = 1'b1; iUpVld = 1'b1; iDnVld = 1'b1; iRshVld = 1'b1;
        tick();
        iUrchVld = 1'b0; iUpVld = 1'b0; iDnVld = 1'b0; iRshVld = 1'b0;
        tick();
        chk("t5.offer_vld", 32'(oSchVld), 32'd1);
        chk_rdy("t5.rdy_three", 4'b0001);
        #2;
        iResetN = 1'b0;
        #1;
        chk_idle("t5.in_reset");
        chk_rdy("t5.rdy_reset", 4'b1111);
        #3;
        iResetN = 1'b1;
        iSchRdy = 1'b1;
        tick();
        chk_idle("t5.post1");
        tick();
        chk_idle("t5.post2");
        chk_rdy("t5.rdy_post", 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
